fwd_hazard_unit: RTL and testbench

//  Parametrised forwarding and hazard unit for the 5-stage pipeline.
//  - Tracks destination-register state for EX/MEM/WB in its own stage registers.
//  - Drives per-read-port forwarding selects for the instruction in EX.
//  - Detects load-use hazards and raises a stall for IF/ID.
//  - Supports flush insertion.
//  - Suppresses forwarding from the hardwired zero register.

---
 rtl/fwd_hazard_unit.sv | 170 +++++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: forwarding and load-use hazard unit for a 5-stage pipeline.
// The unit keeps its own EX/MEM/WB destination-register tracking and produces
// per-read-port forwarding selects for the EX instruction. It also raises a
// one-cycle IF/ID stall for load-use pairs.
// Optional build macro: HAZ_STATS_EN adds a saturating stall-cycle counter on
// stall_cnt. Without it, stall_cnt is tied to zero.
module fwd_hazard_unit #(
    parameter int AW       = 5,
    parameter int NRP      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [NRP*AW-1:0] id_rs,
    input  logic [NRP-1:0]    id_rs_used,
    input  logic [AW-1:0]     id_rd,
    input  logic              id_wen,
    input  logic              id_is_load,
    input  logic              flush,
    output logic              stall,
    output logic [2*NRP-1:0]  fwd_sel,
    output logic [AW-1:0]     mem_rd,
    output logic [AW-1:0]     wb_rd,
    output logic              wb_wen,
    output logic [31:0]       stall_cnt
);

    localparam logic [AW-1:0] ZERO_ADDR = {AW{1'b0}};

    // EX stage tracking
    logic              ex_valid;
    logic [AW-1:0]     ex_rd;
    logic              ex_wen;
    logic              ex_is_load;
    logic [NRP*AW-1:0] ex_rs;
    logic [NRP-1:0]    ex_rs_used;

    // MEM stage tracking
    logic              mem_valid;
    logic [AW-1:0]     mem_rd_q;
    logic              mem_wen;
    logic              mem_is_load;

    // WB stage tracking
    logic              wb_valid;
    logic [AW-1:0]     wb_rd_q;
    logic              wb_wen_q;
    logic              wb_is_load;

    logic              ex_load;

    // A source address matches a stage only if that stage holds a real
    // instruction that writes the address. When ZERO_REG is set, address 0 is
    // hardwired and never matches.
    function automatic logic reg_match(
        input logic [AW-1:0] addr,
        input logic          stg_valid,
        input logic          stg_wen,
        input logic [AW-1:0] stg_rd
    );
        logic zero_blocked;
        zero_blocked = (ZERO_REG != 0) && (addr == ZERO_ADDR);
        return stg_valid && stg_wen && (addr == stg_rd) && !zero_blocked;
    endfunction

    // Load-use detection: ID reads a register that a load in EX will produce
    always_comb begin
        logic hazard;
        hazard = 1'b0;
        for (int p = 0; p < NRP; p++) begin
            if (id_rs_used[p] && reg_match(id_rs[p*AW +: AW], ex_valid, ex_wen, ex_rd)) begin
                hazard = 1'b1;
            end else begin
                hazard = hazard;
            end
        end
        if (id_valid && !flush && ex_is_load && hazard) begin
            stall = 1'b1;
        end else begin
            stall = 1'b0;
        end
    end

    // Forwarding selects per EX read port; MEM holds the newer value and wins
    always_comb begin
        fwd_sel = {(2*NRP){1'b0}};
        for (int p = 0; p < NRP; p++) begin
            if (!ex_rs_used[p]) begin
                fwd_sel[2*p +: 2] = 2'b00;
            end else if (reg_match(ex_rs[p*AW +: AW], mem_valid, mem_wen, mem_rd_q)) begin
                fwd_sel[2*p +: 2] = 2'b10;
            end else if (reg_match(ex_rs[p*AW +: AW], wb_valid, wb_wen_q, wb_rd_q)) begin
                fwd_sel[2*p +: 2] = 2'b01;
            end else begin
                fwd_sel[2*p +: 2] = 2'b00;
            end
        end
    end

    assign ex_load = id_valid && !stall && !flush;

    // Stage advance: back end always moves; EX takes ID or a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_rd       <= ZERO_ADDR;
            ex_wen      <= 1'b0;
            ex_is_load  <= 1'b0;
            ex_rs       <= {(NRP*AW){1'b0}};
            ex_rs_used  <= {NRP{1'b0}};
            mem_valid   <= 1'b0;
            mem_rd_q    <= ZERO_ADDR;
            mem_wen     <= 1'b0;
            mem_is_load <= 1'b0;
            wb_valid    <= 1'b0;
            wb_rd_q     <= ZERO_ADDR;
            wb_wen_q    <= 1'b0;
            wb_is_load  <= 1'b0;
        end else begin
            wb_valid    <= mem_valid;
            wb_rd_q     <= mem_rd_q;
            wb_wen_q    <= mem_wen;
            wb_is_load  <= mem_is_load;
            mem_valid   <= ex_valid;
            mem_rd_q    <= ex_rd;
            mem_wen     <= ex_wen;
            mem_is_load <= ex_is_load;
            if (ex_load) begin
                ex_valid   <= 1'b1;
                ex_rd      <= id_rd;
                ex_wen     <= id_wen;
                ex_is_load <= id_is_load;
                ex_rs      <= id_rs;
                ex_rs_used <= id_rs_used;
            end else begin
                ex_valid   <= 1'b0;
                ex_rd      <= ZERO_ADDR;
                ex_wen     <= 1'b0;
                ex_is_load <= 1'b0;
                ex_rs      <= {(NRP*AW){1'b0}};
                ex_rs_used <= {NRP{1'b0}};
            end
        end
    end

    assign mem_rd = mem_rd_q;
    assign wb_rd  = wb_rd_q;
    assign wb_wen = wb_wen_q;

`ifdef HAZ_STATS_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of cycles spent stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
        end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_q <= stall_cnt_q;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit. Two instances share the stimulus: the main one
// uses ZERO_REG=1 and a second one uses ZERO_REG=0. Expected values are
// queued when stimulus is driven and compared at the following falling edge.
module tb_fwd_hazard_unit;

    localparam int AW  = 5;
    localparam int NRP = 2;

`ifdef HAZ_STATS_EN
    localparam logic [31:0] STATS = 32'd1;
`else
    localparam logic [31:0] STATS = 32'd0;
`endif

    localparam int K_STALL  = 0;
    localparam int K_FWD    = 1;
    localparam int K_FWDZ   = 2;
    localparam int K_MEMRD  = 3;
    localparam int K_WBRD   = 4;
    localparam int K_WBWEN  = 5;
    localparam int K_CNT    = 6;
    localparam int K_STALLZ = 7;

    logic              clk;
    logic              rst;
    logic              id_valid;
    logic [NRP*AW-1:0] id_rs;
    logic [NRP-1:0]    id_rs_used;
    logic [AW-1:0]     id_rd;
    logic              id_wen;
    logic              id_is_load;
    logic              flush;

    logic              stall;
    logic [2*NRP-1:0]  fwd_sel;
    logic [AW-1:0]     mem_rd;
    logic [AW-1:0]     wb_rd;
    logic              wb_wen;
    logic [31:0]       stall_cnt;

    logic              stall_z;
    logic [2*NRP-1:0]  fwd_sel_z;
    logic [AW-1:0]     mem_rd_z;
    logic [AW-1:0]     wb_rd_z;
    logic              wb_wen_z;
    logic [31:0]       stall_cnt_z;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    fwd_hazard_unit #(.AW(AW), .NRP(NRP), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .id_rd(id_rd), .id_wen(id_wen),
        .id_is_load(id_is_load), .flush(flush), .stall(stall),
        .fwd_sel(fwd_sel), .mem_rd(mem_rd), .wb_rd(wb_rd), .wb_wen(wb_wen),
        .stall_cnt(stall_cnt)
    );

    fwd_hazard_unit #(.AW(AW), .NRP(NRP), .ZERO_REG(0)) dut_z (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .id_rd(id_rd), .id_wen(id_wen),
        .id_is_load(id_is_load), .flush(flush), .stall(stall_z),
        .fwd_sel(fwd_sel_z), .mem_rd(mem_rd_z), .wb_rd(wb_rd_z), .wb_wen(wb_wen_z),
        .stall_cnt(stall_cnt_z)
    );

    // free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_val(input string tag, input int kind, input logic [31:0] v);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.exp  = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                K_STALL:  obs = {31'd0, stall};
                K_FWD:    obs = {28'd0, fwd_sel};
                K_FWDZ:   obs = {28'd0, fwd_sel_z};
                K_MEMRD:  obs = {27'd0, mem_rd};
                K_WBRD:   obs = {27'd0, wb_rd};
                K_WBWEN:  obs = {31'd0, wb_wen};
                K_CNT:    obs = stall_cnt;
                K_STALLZ: obs = {31'd0, stall_z};
                default:  obs = 32'hDEAD_BEEF;
            endcase
            check_eq(e.tag, obs, e.exp);
        end
    endtask

    // compare queued expectations mid-cycle
    always @(negedge clk) begin
        drain();
    end

    // present one ID instruction just after a rising edge
    task automatic step(input logic v, input logic [AW-1:0] rs0, input logic [AW-1:0] rs1,
                        input logic [1:0] used, input logic [AW-1:0] rd,
                        input logic wen, input logic ld, input logic fl);
        @(posedge clk);
        #1;
        id_valid   = v;
        id_rs      = {rs1, rs0};
        id_rs_used = used;
        id_rd      = rd;
        id_wen     = wen;
        id_is_load = ld;
        flush      = fl;
    endtask

    task automatic nop();
        step(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        id_valid = 1'b0; id_rs = '0; id_rs_used = 2'b00; id_rd = 5'd0;
        id_wen = 1'b0; id_is_load = 1'b0; flush = 1'b0;
        #1 rst = 1'b1;
        #1;
        expect_val("rst_stall", K_STALL, 32'd0);
        expect_val("rst_fwd", K_FWD, 32'd0);
        expect_val("rst_memrd", K_MEMRD, 32'd0);
        expect_val("rst_wbrd", K_WBRD, 32'd0);
        expect_val("rst_wbwen", K_WBWEN, 32'd0);
        expect_val("rst_cnt", K_CNT, 32'd0);
        drain();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // ALU chain: distance 1 -> MEM, distance 2 -> WB, distance 3 -> RF
        step(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd3, 5'd0, 2'b01, 5'd10, 1'b1, 1'b0, 1'b0);
        expect_val("alu_nostall", K_STALL, 32'd0);
        nop();
        expect_val("alu_mem", K_FWD, 32'h2);
        expect_val("alu_mem_z", K_FWDZ, 32'h2);
        expect_val("alu_memrd", K_MEMRD, 32'd3);
        step(1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b0, 1'b0);
        expect_val("alu_wbrd", K_WBRD, 32'd3);
        expect_val("alu_wbwen", K_WBWEN, 32'd1);
        nop();
        step(1'b1, 5'd4, 5'd0, 2'b01, 5'd11, 1'b1, 1'b0, 1'b0);
        nop();
        expect_val("alu_wb", K_FWD, 32'h1);
        step(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 1'b0, 1'b0);
        nop();
        nop();
        step(1'b1, 5'd6, 5'd0, 2'b01, 5'd12, 1'b1, 1'b0, 1'b0);
        nop();
        expect_val("alu_rf", K_FWD, 32'h0);

        // load-use: one stall, then forward from WB
        step(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b1, 1'b0);
        step(1'b1, 5'd5, 5'd0, 2'b01, 5'd12, 1'b1, 1'b0, 1'b0);
        expect_val("lu_stall", K_STALL, 32'd1);
        expect_val("lu_stall_z", K_STALLZ, 32'd1);
        step(1'b1, 5'd5, 5'd0, 2'b01, 5'd12, 1'b1, 1'b0, 1'b0);
        expect_val("lu_once", K_STALL, 32'd0);
        expect_val("lu_bubble", K_FWD, 32'h0);
        expect_val("lu_memrd", K_MEMRD, 32'd5);
        nop();
        expect_val("lu_wb", K_FWD, 32'h1);
        expect_val("lu_cnt", K_CNT, STATS);

        // zero register
        step(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd0, 5'd0, 2'b11, 5'd13, 1'b1, 1'b0, 1'b0);
        nop();
        expect_val("zr_fwd", K_FWD, 32'h0);
        expect_val("zr_fwd_z", K_FWDZ, 32'hA);
        step(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 5'd0, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
        expect_val("zr_nostall", K_STALL, 32'd0);
        expect_val("zr_stall_z", K_STALLZ, 32'd1);
        nop();
        nop();
        nop();

        // priority MEM over WB, independent ports, unused port
        step(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd7, 5'd7, 2'b11, 5'd14, 1'b1, 1'b0, 1'b0);
        nop();
        expect_val("prio_fwd", K_FWD, 32'hA);
        expect_val("prio_fwd_z", K_FWDZ, 32'hA);
        expect_val("prio_memrd", K_MEMRD, 32'd7);
        expect_val("prio_wbrd", K_WBRD, 32'd7);
        step(1'b1, 5'd0, 5'd0, 2'b00, 5'd8, 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd8, 5'd9, 2'b11, 5'd15, 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd9, 5'd9, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
        expect_val("port_indep", K_FWD, 32'h9);

        // flush against a load-use hazard
        step(1'b1, 5'd0, 5'd0, 2'b00, 5'd2, 1'b1, 1'b1, 1'b0);
        expect_val("port_unused", K_FWD, 32'h1);
        step(1'b1, 5'd2, 5'd0, 2'b01, 5'd20, 1'b1, 1'b0, 1'b1);
        expect_val("fl_nostall", K_STALL, 32'd0);
        expect_val("fl_nostall_z", K_STALLZ, 32'd0);
        step(1'b1, 5'd20, 5'd2, 2'b11, 5'd21, 1'b1, 1'b0, 1'b0);
        expect_val("fl_memrd", K_MEMRD, 32'd2);
        expect_val("fl_ex_bubble", K_STALL, 32'd0);
        step(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 1'b0, 1'b0);
        expect_val("fl_fwd", K_FWD, 32'h4);

        // asynchronous reset with a load in EX and a hazard pending
        step(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b1, 1'b0);
        step(1'b1, 5'd5, 5'd0, 2'b01, 5'd22, 1'b1, 1'b0, 1'b0);
        expect_val("pre_rst_stall", K_STALL, 32'd1);
        expect_val("pre_rst_wbwen", K_WBWEN, 32'd1);
        expect_val("pre_rst_memrd", K_MEMRD, 32'd6);
        expect_val("pre_rst_cnt", K_CNT, STATS);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        expect_val("arst_stall", K_STALL, 32'd0);
        expect_val("arst_fwd", K_FWD, 32'h0);
        expect_val("arst_wbwen", K_WBWEN, 32'd0);
        expect_val("arst_memrd", K_MEMRD, 32'd0);
        expect_val("arst_wbrd", K_WBRD, 32'd0);
        expect_val("arst_cnt", K_CNT, 32'd0);
        expect_val("arst_stall_z", K_STALLZ, 32'd0);
        drain();
        @(posedge clk);
        #1 rst = 1'b0;
        expect_val("post_rst_nostall", K_STALL, 32'd0);
        nop();
        expect_val("post_rst_fwd", K_FWD, 32'h0);
        expect_val("post_rst_cnt", K_CNT, 32'd0);
        nop();
        nop();
        if (sb.size() != 0) begin
            check_eq("sb_empty", sb.size(), 32'd0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
